// File: rtl/sc_frog_position_reg.sv
// Frog position register: executes point-FSM move commands, tracks row/column, scores goals, respawns.
// Latency: one cycle from sampled command to updated registered outputs.
// Backpressure: none. Every cycle with a low command is one move, and all commands are ignored while in GOAL.
//
// Ports:
//   SC_FROGPOSITION_CLOCK_50           clock
//   SC_FROGPOSITION_RESET_InLow        async reset, active-low
//   SC_FROGPOSITION_load0_InLow        move down one row (active-low)
//   SC_FROGPOSITION_load1_InLow        move up one row (active-low)
//   SC_FROGPOSITION_shiftselection_In  01 left, 10 right, 00/11 hold
//   SC_FROGPOSITION_clear_InLow        sync respawn + score clear (active-low)
//   SC_FROGPOSITION_row_Out            row index, 0 = bottom/start row
//   SC_FROGPOSITION_column_Out         one-hot column
//   SC_FROGPOSITION_firstreg_OutLow    0 when row==0
//   SC_FROGPOSITION_goal_OutHigh       1 while the goal display is held
//   SC_FROGPOSITION_score_Out          goals reached, saturating at 255
module sc_frog_position_reg #(
   parameter int ROWS             = 8,
   parameter int COLS             = 8,
   parameter int START_COL        = 3,
   parameter int GOAL_HOLD_CYCLES = 50000000
) (
   input  logic                    SC_FROGPOSITION_CLOCK_50,
   input  logic                    SC_FROGPOSITION_RESET_InLow,
   input  logic                    SC_FROGPOSITION_load0_InLow,
   input  logic                    SC_FROGPOSITION_load1_InLow,
   input  logic [1:0]              SC_FROGPOSITION_shiftselection_In,
   input  logic                    SC_FROGPOSITION_clear_InLow,
   output logic [$clog2(ROWS)-1:0] SC_FROGPOSITION_row_Out,
   output logic [COLS-1:0]         SC_FROGPOSITION_column_Out,
   output logic                    SC_FROGPOSITION_firstreg_OutLow,
   output logic                    SC_FROGPOSITION_goal_OutHigh,
   output logic [7:0]              SC_FROGPOSITION_score_Out
);

   localparam int RW = $clog2(ROWS);
   localparam int HW = (GOAL_HOLD_CYCLES > 1) ? $clog2(GOAL_HOLD_CYCLES) : 1;

   localparam logic [RW-1:0]   ROW_TOP   = RW'(ROWS - 1);
   localparam logic [RW-1:0]   ROW_PRE   = RW'(ROWS - 2);
   localparam logic [COLS-1:0] COL_START = COLS'(1) << START_COL;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(GOAL_HOLD_CYCLES - 1);

   // Two-bit encoding so corrupted values (00/11) exist and are caught by the default arm.
   typedef enum logic [1:0] {
      PLAY = 2'b01,
      GOAL = 2'b10
   } stateT;

   stateT           state,     stateNext;
   logic [RW-1:0]   rowQ,      rowNext;
   logic [COLS-1:0] colQ,      colNext;
   logic            firstQ,    firstNext;
   logic            goalQ,     goalNext;
   logic [7:0]      scoreQ,    scoreNext;
   logic [HW-1:0]   holdQ,     holdNext;

   always_ff @(posedge SC_FROGPOSITION_CLOCK_50 or negedge SC_FROGPOSITION_RESET_InLow) begin
      if (!SC_FROGPOSITION_RESET_InLow) begin
         state  <= PLAY;
         rowQ   <= '0;
         colQ   <= COL_START;
         firstQ <= 1'b0;
         goalQ  <= 1'b0;
         scoreQ <= '0;
         holdQ  <= '0;
      end else begin
         state  <= stateNext;
         rowQ   <= rowNext;
         colQ   <= colNext;
         firstQ <= firstNext;
         goalQ  <= goalNext;
         scoreQ <= scoreNext;
         holdQ  <= holdNext;
      end
   end

   always_comb begin
      stateNext = state;
      rowNext   = rowQ;
      colNext   = colQ;
      scoreNext = scoreQ;
      holdNext  = holdQ;

      case (state)
         PLAY: begin
            if (!SC_FROGPOSITION_clear_InLow) begin
               rowNext   = '0;
               colNext   = COL_START;
               scoreNext = '0;
            end else if (!SC_FROGPOSITION_load0_InLow && !SC_FROGPOSITION_load1_InLow) begin
               // Contradictory up+down request: hold position, shift also suppressed.
            end else if (!SC_FROGPOSITION_load1_InLow) begin
               if (rowQ == ROW_PRE) begin
                  rowNext   = ROW_TOP;
                  scoreNext = (scoreQ == 8'hFF) ? scoreQ : scoreQ + 8'd1;
                  holdNext  = '0;
                  stateNext = GOAL;
               end else if (rowQ < ROW_PRE) begin
                  rowNext = rowQ + 1'b1;
               end
            end else if (!SC_FROGPOSITION_load0_InLow) begin
               if (rowQ != '0) begin
                  rowNext = rowQ - 1'b1;
               end
            end else if (SC_FROGPOSITION_shiftselection_In == 2'b01) begin
               // Saturate at the edge so the vector stays one-hot.
               if (!colQ[COLS-1]) begin
                  colNext = colQ << 1;
               end
            end else if (SC_FROGPOSITION_shiftselection_In == 2'b10) begin
               if (!colQ[0]) begin
                  colNext = colQ >> 1;
               end
            end
         end
         GOAL: begin
            if (holdQ == HOLD_LAST) begin
               rowNext   = '0;
               colNext   = COL_START;
               holdNext  = '0;
               stateNext = PLAY;
            end else begin
               holdNext = holdQ + 1'b1;
            end
         end
         default: begin
            stateNext = PLAY;
            rowNext   = '0;
            colNext   = COL_START;
            holdNext  = '0;
         end
      endcase

      // Flags are computed from next-state values so they register in step with row/state.
      firstNext = (rowNext != '0);
      goalNext  = (stateNext == GOAL);
   end

   assign SC_FROGPOSITION_row_Out         = rowQ;
   assign SC_FROGPOSITION_column_Out      = colQ;
   assign SC_FROGPOSITION_firstreg_OutLow = firstQ;
   assign SC_FROGPOSITION_goal_OutHigh    = goalQ;
   assign SC_FROGPOSITION_score_Out       = scoreQ;

endmodule
